// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 burst master.
package axi4_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_e;

  // True when a burst of (len+1) 4-byte beats from addr runs past the 64-byte space.
  function automatic logic range_err(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len);
    logic [10:0] end_b;
    end_b = {5'd0, addr} + (({3'd0, len} + 11'd1) << 2);
    return end_b > 11'd64;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Single-command AXI4 INCR burst master (read or write, 4-byte beats).
// Optional feature: define AXI_MASTER_ERRCNT_EN to add a saturating err_count output.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter logic [1:0] AXI_ID    = 2'b11,
  parameter logic [3:0] WSTRB_VAL = 4'hF
) (
  input  logic              m00_axi_aclk,
  input  logic              m00_axi_aresetn,
  // Command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // Write-data stream
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // Read-data stream
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_ready,
  // Status
  output logic              done,
  output logic              err,
`ifdef AXI_MASTER_ERRCNT_EN
  output logic [15:0]       err_count,
`endif
  // AXI write address
  output logic [ADDR_W-1:0] m00_axi_awaddr,
  output logic [LEN_W-1:0]  m00_axi_awlen,
  output logic [2:0]        m00_axi_awsize,
  output logic [1:0]        m00_axi_awburst,
  output logic [1:0]        m00_axi_awid,
  output logic              m00_axi_awvalid,
  input  logic              m00_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0] m00_axi_wdata,
  output logic [3:0]        m00_axi_wstrb,
  output logic              m00_axi_wlast,
  output logic              m00_axi_wvalid,
  input  logic              m00_axi_wready,
  // AXI write response
  input  logic [1:0]        m00_axi_bresp,
  input  logic [1:0]        m00_axi_bid,
  input  logic              m00_axi_bvalid,
  output logic              m00_axi_bready,
  // AXI read
  output logic [ADDR_W-1:0] m00_axi_araddr,
  output logic [LEN_W-1:0]  m00_axi_arlen,
  output logic [2:0]        m00_axi_arsize,
  output logic [1:0]        m00_axi_arburst,
  output logic [1:0]        m00_axi_arid,
  output logic              m00_axi_arvalid,
  input  logic              m00_axi_arready,
  input  logic [DATA_W-1:0] m00_axi_rdata,
  input  logic [1:0]        m00_axi_rresp,
  input  logic              m00_axi_rlast,
  input  logic              m00_axi_rvalid,
  output logic              m00_axi_rready
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_err;
  logic              w_w_hs;
  logic              w_r_hs;

  // Control outputs decode straight from the state register, so no valid depends on its ready.
  assign cmd_ready       = (r_state == IDLE);
  assign m00_axi_awvalid = (r_state == WADDR);
  assign m00_axi_wvalid  = (r_state == WDATA) && wr_valid;
  assign m00_axi_wlast   = (r_state == WDATA) && (r_cnt == r_len);
  assign wr_ready        = (r_state == WDATA) && m00_axi_wready;
  assign m00_axi_bready  = (r_state == WRESP);
  assign m00_axi_arvalid = (r_state == RADDR);
  assign m00_axi_rready  = (r_state == RDATA) && rd_ready;
  assign rd_valid        = (r_state == RDATA) && m00_axi_rvalid;
  assign rd_last         = (r_state == RDATA) && m00_axi_rlast;
  assign rd_data         = m00_axi_rdata;
  assign done            = (r_state == DONE);
  assign err             = r_err;

  assign m00_axi_awaddr  = r_addr;
  assign m00_axi_awlen   = r_len;
  assign m00_axi_awsize  = AXI_SIZE_4B;
  assign m00_axi_awburst = AXI_BURST_INCR;
  assign m00_axi_awid    = AXI_ID;
  assign m00_axi_wdata   = wr_data;
  assign m00_axi_wstrb   = WSTRB_VAL;
  assign m00_axi_araddr  = r_addr;
  assign m00_axi_arlen   = r_len;
  assign m00_axi_arsize  = AXI_SIZE_4B;
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arid    = AXI_ID;

  assign w_w_hs = m00_axi_wvalid && m00_axi_wready;
  assign w_r_hs = rd_valid && rd_ready;

  // Main burst FSM: command capture, address phase, data beats, response, done pulse.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            r_cnt  <= '0;
            if (range_err(cmd_addr, cmd_len)) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= cmd_write ? WADDR : RADDR;
            end
          end
        end
        WADDR: if (m00_axi_awready) r_state <= WDATA;
        WDATA: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_len) r_state <= WRESP;
          end
        end
        WRESP: begin
          if (m00_axi_bvalid) begin
            if (m00_axi_bresp != AXI_RESP_OKAY || m00_axi_bid != AXI_ID) r_err <= 1'b1;
            r_state <= DONE;
          end
        end
        RADDR: if (m00_axi_arready) r_state <= RDATA;
        RDATA: begin
          if (w_r_hs) begin
            if (m00_axi_rresp != AXI_RESP_OKAY) r_err <= 1'b1;
            if (m00_axi_rlast) begin
              // A short burst (rlast before the final expected beat) is an error.
              if (r_cnt != r_len) r_err <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_ERRCNT_EN
  logic [15:0] r_err_count;

  // Count completed commands that ended in error, saturating at all-ones.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_err_count <= '0;
    end else if ((r_state == DONE) && r_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
